// File: rtl/ex_stage.sv
// ex_stage: execute stage of the lapido pipeline.
// Resolves operands through MEM/WB forwarding, runs the ALU, keeps the
// architectural flag register and registers results into EX/MEM.
module ex_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int PC_WIDTH   = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  flush,
  input  logic [5:0]            in_alu_funct,
  input  logic                  in_alu_src_mux,
  input  logic [1:0]            in_reg_dst_mux,
  input  logic                  in_is_load,
  input  logic                  in_fl_write_enable,
  input  logic                  in_mem_write_enable,
  input  logic                  in_sel_beq_bne,
  input  logic                  in_sel_jt_jf,
  input  logic                  in_is_branch,
  input  logic                  in_sel_jflag_branch,
  input  logic                  in_reg_write_enable,
  input  logic [1:0]            in_wb_res_mux,
  input  logic [4:0]            in_rd,
  input  logic [4:0]            in_rs,
  input  logic [4:0]            in_rt,
  input  logic [DATA_WIDTH-1:0] in_imm,
  input  logic [PC_WIDTH-1:0]   in_next_pc,
  input  logic [DATA_WIDTH-1:0] in_data_rs,
  input  logic [DATA_WIDTH-1:0] in_data_rt,
  input  logic                  mem_reg_write_enable,
  input  logic                  wb_reg_write_enable,
  input  logic [4:0]            mem_wr_addr,
  input  logic [4:0]            wb_wr_addr,
  input  logic [DATA_WIDTH-1:0] mem_alu_result,
  input  logic [DATA_WIDTH-1:0] wb_data,
  output logic [DATA_WIDTH-1:0] out_alu_result,
  output logic [DATA_WIDTH-1:0] out_store_data,
  output logic [PC_WIDTH-1:0]   out_branch_target,
  output logic [4:0]            out_wr_addr,
  output logic [3:0]            out_flags,
  output logic                  out_zero,
  output logic                  out_is_load,
  output logic                  out_mem_write_enable,
  output logic                  out_sel_beq_bne,
  output logic                  out_sel_jt_jf,
  output logic                  out_is_branch,
  output logic                  out_sel_jflag_branch,
  output logic                  out_reg_write_enable,
  output logic [1:0]            out_wb_res_mux,
  output logic [PC_WIDTH-1:0]   out_next_pc
);

  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_LUI  = 6'h0F;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A;
  localparam logic [5:0] F_PASS = 6'h3F;

  localparam int MSB = DATA_WIDTH - 1;

  logic [DATA_WIDTH-1:0] fwd_rs, fwd_rt, op_a, op_b;
  logic [DATA_WIDTH-1:0] alu_res;
  logic [DATA_WIDTH:0]   add_ext, sub_ext;
  logic [4:0]            shamt;
  logic                  alu_carry, alu_ovf, alu_valid;
  logic [3:0]            alu_flags;
  logic [4:0]            wr_addr;
  logic [PC_WIDTH-1:0]   imm_pc, branch_target;

  // Operand forwarding: the younger MEM result wins over WB, then the register file.
  always_comb begin
    fwd_rs = in_data_rs;
    if (mem_reg_write_enable && (mem_wr_addr == in_rs))
      fwd_rs = mem_alu_result;
    else if (wb_reg_write_enable && (wb_wr_addr == in_rs))
      fwd_rs = wb_data;

    fwd_rt = in_data_rt;
    if (mem_reg_write_enable && (mem_wr_addr == in_rt))
      fwd_rt = mem_alu_result;
    else if (wb_reg_write_enable && (wb_wr_addr == in_rt))
      fwd_rt = wb_data;
  end

  assign op_a    = fwd_rs;
  assign op_b    = in_alu_src_mux ? in_imm : fwd_rt;
  assign shamt   = op_a[4:0];
  // One extra bit holds the carry-out on add and the borrow on sub.
  assign add_ext = {1'b0, op_a} + {1'b0, op_b};
  assign sub_ext = {1'b0, op_a} - {1'b0, op_b};

  // ALU datapath and per-operation carry/overflow; unknown codes yield zero and no flags.
  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    alu_ovf   = 1'b0;
    alu_valid = 1'b1;
    case (in_alu_funct)
      F_ADD: begin
        alu_res   = add_ext[MSB:0];
        alu_carry = add_ext[DATA_WIDTH];
        alu_ovf   = (op_a[MSB] == op_b[MSB]) && (alu_res[MSB] != op_a[MSB]);
      end
      F_SUB: begin
        alu_res   = sub_ext[MSB:0];
        alu_carry = sub_ext[DATA_WIDTH];
        alu_ovf   = (op_a[MSB] != op_b[MSB]) && (alu_res[MSB] != op_a[MSB]);
      end
      F_AND:  alu_res = op_a & op_b;
      F_OR:   alu_res = op_a | op_b;
      F_XOR:  alu_res = op_a ^ op_b;
      F_NOR:  alu_res = ~(op_a | op_b);
      F_SLT:  alu_res = DATA_WIDTH'($signed(op_a) < $signed(op_b));
      F_SLL:  alu_res = op_b << shamt;
      F_SRL:  alu_res = op_b >> shamt;
      F_SRA:  alu_res = $unsigned($signed(op_b) >>> shamt);
      F_LUI:  alu_res = op_b << 16;
      F_PASS: alu_res = op_b;
      default: begin
        alu_res   = '0;
        alu_valid = 1'b0;
      end
    endcase
  end

  assign alu_flags = alu_valid ? {alu_ovf, alu_carry, alu_res[MSB], (alu_res == '0)} : 4'b0000;

  // Destination register select.
  always_comb begin
    case (in_reg_dst_mux)
      2'd0:    wr_addr = in_rt;
      2'd1:    wr_addr = in_rd;
      2'd2:    wr_addr = 5'd31;
      default: wr_addr = 5'd0;
    endcase
  end

  assign imm_pc        = PC_WIDTH'(in_imm);
  assign branch_target = in_next_pc + imm_pc;

  // EX/MEM pipeline register: reset, then flush (bubble), then stall (hold), else capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_alu_result       <= '0;
      out_store_data       <= '0;
      out_branch_target    <= '0;
      out_wr_addr          <= '0;
      out_zero             <= 1'b0;
      out_is_load          <= 1'b0;
      out_mem_write_enable <= 1'b0;
      out_sel_beq_bne      <= 1'b0;
      out_sel_jt_jf        <= 1'b0;
      out_is_branch        <= 1'b0;
      out_sel_jflag_branch <= 1'b0;
      out_reg_write_enable <= 1'b0;
      out_wb_res_mux       <= '0;
      out_next_pc          <= '0;
    end else if (flush || !stall) begin
      out_alu_result       <= alu_res;
      out_store_data       <= fwd_rt;
      out_branch_target    <= branch_target;
      out_wr_addr          <= wr_addr;
      out_zero             <= (alu_res == '0);
      out_next_pc          <= in_next_pc;
      // A flushed slot keeps its data but carries no side effects.
      out_is_load          <= in_is_load && !flush;
      out_mem_write_enable <= in_mem_write_enable && !flush;
      out_sel_beq_bne      <= in_sel_beq_bne && !flush;
      out_sel_jt_jf        <= in_sel_jt_jf && !flush;
      out_is_branch        <= in_is_branch && !flush;
      out_sel_jflag_branch <= in_sel_jflag_branch && !flush;
      out_reg_write_enable <= in_reg_write_enable && !flush;
      out_wb_res_mux       <= flush ? 2'b00 : in_wb_res_mux;
    end
  end

  // Architectural flag register: only a live, flag-writing instruction updates it.
  always_ff @(posedge clk) begin
    if (rst)
      out_flags <= 4'b0000;
    else if (in_fl_write_enable && !stall && !flush)
      out_flags <= alu_flags;
  end

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: vector table, directed corner sequences and random traffic
// against an arithmetic reference model of the execute stage.
module tb_ex_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, stall, flush;
  logic [5:0]  in_alu_funct;
  logic        in_alu_src_mux;
  logic [1:0]  in_reg_dst_mux;
  logic        in_is_load, in_fl_write_enable, in_mem_write_enable, in_sel_beq_bne;
  logic        in_sel_jt_jf, in_is_branch, in_sel_jflag_branch, in_reg_write_enable;
  logic [1:0]  in_wb_res_mux;
  logic [4:0]  in_rd, in_rs, in_rt;
  logic [31:0] in_imm, in_next_pc, in_data_rs, in_data_rt;
  logic        mem_reg_write_enable, wb_reg_write_enable;
  logic [4:0]  mem_wr_addr, wb_wr_addr;
  logic [31:0] mem_alu_result, wb_data;
  logic [31:0] out_alu_result, out_store_data, out_branch_target, out_next_pc;
  logic [4:0]  out_wr_addr;
  logic [3:0]  out_flags;
  logic        out_zero, out_is_load, out_mem_write_enable, out_sel_beq_bne;
  logic        out_sel_jt_jf, out_is_branch, out_sel_jflag_branch, out_reg_write_enable;
  logic [1:0]  out_wb_res_mux;

  ex_stage #(.DATA_WIDTH(32), .PC_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .in_alu_funct(in_alu_funct), .in_alu_src_mux(in_alu_src_mux),
    .in_reg_dst_mux(in_reg_dst_mux), .in_is_load(in_is_load),
    .in_fl_write_enable(in_fl_write_enable), .in_mem_write_enable(in_mem_write_enable),
    .in_sel_beq_bne(in_sel_beq_bne), .in_sel_jt_jf(in_sel_jt_jf),
    .in_is_branch(in_is_branch), .in_sel_jflag_branch(in_sel_jflag_branch),
    .in_reg_write_enable(in_reg_write_enable), .in_wb_res_mux(in_wb_res_mux),
    .in_rd(in_rd), .in_rs(in_rs), .in_rt(in_rt), .in_imm(in_imm),
    .in_next_pc(in_next_pc), .in_data_rs(in_data_rs), .in_data_rt(in_data_rt),
    .mem_reg_write_enable(mem_reg_write_enable), .wb_reg_write_enable(wb_reg_write_enable),
    .mem_wr_addr(mem_wr_addr), .wb_wr_addr(wb_wr_addr),
    .mem_alu_result(mem_alu_result), .wb_data(wb_data),
    .out_alu_result(out_alu_result), .out_store_data(out_store_data),
    .out_branch_target(out_branch_target), .out_wr_addr(out_wr_addr),
    .out_flags(out_flags), .out_zero(out_zero), .out_is_load(out_is_load),
    .out_mem_write_enable(out_mem_write_enable), .out_sel_beq_bne(out_sel_beq_bne),
    .out_sel_jt_jf(out_sel_jt_jf), .out_is_branch(out_is_branch),
    .out_sel_jflag_branch(out_sel_jflag_branch), .out_reg_write_enable(out_reg_write_enable),
    .out_wb_res_mux(out_wb_res_mux), .out_next_pc(out_next_pc)
  );

  typedef struct {
    logic [31:0] alu_result, store_data, branch_target, next_pc;
    logic [4:0]  wr_addr;
    logic [3:0]  flags;
    logic        zero, is_load, mem_we, beq_bne, jt_jf, is_branch, jflag_branch, reg_we;
    logic [1:0]  wb_res_mux;
  } out_t;

  typedef struct {
    logic [5:0]  funct;
    logic [31:0] a, b, imm;
    logic        alu_src;
    logic [1:0]  reg_dst;
    logic [4:0]  rt, rd;
    logic [31:0] exp_res;
    logic [3:0]  exp_flags;
    logic [4:0]  exp_wr;
  } vec_t;

  out_t exp_o;
  int   n_checks = 0;
  int   n_pass   = 0;
  vec_t vecs[19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  function automatic logic [31:0] fwd_ref(input logic [4:0] field, input logic [31:0] rf);
    if (mem_reg_write_enable && mem_wr_addr == field) return mem_alu_result;
    if (wb_reg_write_enable && wb_wr_addr == field) return wb_data;
    return rf;
  endfunction

  // Arithmetic reference: results and flags from integer math on 64-bit values.
  function automatic void alu_ref(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic [3:0] fl);
    longint ua, ub, sa, sb, wide;
    longint lim_hi, lim_lo;
    logic c, v, ok;
    int sh;
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    lim_hi = 64'sd2147483647;
    lim_lo = -64'sd2147483648;
    sh = int'(a[4:0]);
    c = 1'b0; v = 1'b0; ok = 1'b1; wide = 0;
    case (f)
      6'h20: begin
        wide = ua + ub; r = wide[31:0]; c = (wide >= 64'h1_0000_0000);
        v = (sa + sb > lim_hi) || (sa + sb < lim_lo);
      end
      6'h22: begin
        wide = sa - sb; r = wide[31:0]; c = (ua < ub);
        v = (wide > lim_hi) || (wide < lim_lo);
      end
      6'h24: r = a & b;
      6'h25: r = a | b;
      6'h26: r = a ^ b;
      6'h27: r = ~(a | b);
      6'h2A: r = (sa < sb) ? 32'd1 : 32'd0;
      6'h00: begin wide = ub * (64'd1 << sh); r = wide[31:0]; end
      6'h02: begin wide = ub / (64'd1 << sh); r = wide[31:0]; end
      6'h03: begin wide = sb >>> sh; r = wide[31:0]; end
      6'h0F: begin wide = ub * 65536; r = wide[31:0]; end
      6'h3F: r = b;
      default: begin r = 32'd0; ok = 1'b0; end
    endcase
    fl = ok ? {v, c, r[31], (r == 32'd0)} : 4'b0000;
  endfunction

  function automatic out_t predict(input out_t cur);
    out_t n;
    logic [31:0] a, b, r;
    logic [3:0]  fl;
    n = cur;
    if (rst) begin
      n = '{default: '0};
      return n;
    end
    a = fwd_ref(in_rs, in_data_rs);
    b = in_alu_src_mux ? in_imm : fwd_ref(in_rt, in_data_rt);
    alu_ref(in_alu_funct, a, b, r, fl);
    if (in_fl_write_enable && !stall && !flush) n.flags = fl;
    if (flush || !stall) begin
      n.alu_result    = r;
      n.store_data    = fwd_ref(in_rt, in_data_rt);
      n.branch_target = in_next_pc + in_imm;
      n.next_pc       = in_next_pc;
      n.zero          = (r == 32'd0);
      case (in_reg_dst_mux)
        2'd0: n.wr_addr = in_rt;
        2'd1: n.wr_addr = in_rd;
        2'd2: n.wr_addr = 5'd31;
        default: n.wr_addr = 5'd0;
      endcase
      n.is_load = in_is_load;         n.mem_we = in_mem_write_enable;
      n.beq_bne = in_sel_beq_bne;     n.jt_jf = in_sel_jt_jf;
      n.is_branch = in_is_branch;     n.jflag_branch = in_sel_jflag_branch;
      n.reg_we = in_reg_write_enable; n.wb_res_mux = in_wb_res_mux;
      if (flush) begin
        n.is_load = 0; n.mem_we = 0; n.beq_bne = 0; n.jt_jf = 0;
        n.is_branch = 0; n.jflag_branch = 0; n.reg_we = 0; n.wb_res_mux = 0;
      end
    end
    return n;
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".alu_result"}, out_alu_result, exp_o.alu_result);
    chk({tag, ".store_data"}, out_store_data, exp_o.store_data);
    chk({tag, ".branch_target"}, out_branch_target, exp_o.branch_target);
    chk({tag, ".next_pc"}, out_next_pc, exp_o.next_pc);
    chk({tag, ".wr_addr"}, 32'(out_wr_addr), 32'(exp_o.wr_addr));
    chk({tag, ".flags"}, 32'(out_flags), 32'(exp_o.flags));
    chk({tag, ".zero"}, 32'(out_zero), 32'(exp_o.zero));
    chk({tag, ".ctrl"},
        32'({out_is_load, out_mem_write_enable, out_sel_beq_bne, out_sel_jt_jf,
             out_is_branch, out_sel_jflag_branch, out_reg_write_enable, out_wb_res_mux}),
        32'({exp_o.is_load, exp_o.mem_we, exp_o.beq_bne, exp_o.jt_jf,
             exp_o.is_branch, exp_o.jflag_branch, exp_o.reg_we, exp_o.wb_res_mux}));
  endtask

  // One clock: predict from the inputs in place, step the edge, compare off-edge.
  task automatic cycle(input string tag);
    out_t nxt;
    nxt = predict(exp_o);
    @(posedge clk);
    #1;
    exp_o = nxt;
    check_all(tag);
  endtask

  task automatic clear_inputs();
    in_alu_funct = 6'h3F; in_alu_src_mux = 0; in_reg_dst_mux = 0;
    in_is_load = 0; in_fl_write_enable = 0; in_mem_write_enable = 0; in_sel_beq_bne = 0;
    in_sel_jt_jf = 0; in_is_branch = 0; in_sel_jflag_branch = 0; in_reg_write_enable = 0;
    in_wb_res_mux = 0; in_rd = 0; in_rs = 0; in_rt = 0; in_imm = 0; in_next_pc = 0;
    in_data_rs = 0; in_data_rt = 0;
    mem_reg_write_enable = 0; wb_reg_write_enable = 0; mem_wr_addr = 0; wb_wr_addr = 0;
    mem_alu_result = 0; wb_data = 0;
  endtask

  task automatic rand_inputs();
    logic [5:0] codes[12];
    codes = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h00, 6'h02, 6'h03, 6'h0F, 6'h3F};
    if ($urandom_range(0, 9) == 0) in_alu_funct = 6'($urandom);
    else in_alu_funct = codes[$urandom_range(0, 11)];
    in_alu_src_mux = 1'($urandom); in_reg_dst_mux = 2'($urandom);
    {in_is_load, in_fl_write_enable, in_mem_write_enable, in_sel_beq_bne,
     in_sel_jt_jf, in_is_branch, in_sel_jflag_branch, in_reg_write_enable} = 8'($urandom);
    in_wb_res_mux = 2'($urandom);
    in_rd = 5'($urandom); in_rs = 5'($urandom_range(0, 3)); in_rt = 5'($urandom_range(0, 3));
    case ($urandom_range(0, 3))
      0: in_imm = 32'hFFFF_FFFF;
      1: in_imm = 32'h8000_0000;
      default: in_imm = $urandom;
    endcase
    in_next_pc = $urandom; in_data_rs = $urandom; in_data_rt = $urandom;
    if ($urandom_range(0, 3) == 0) in_data_rs = 32'h7FFF_FFFF;
    mem_reg_write_enable = 1'($urandom); wb_reg_write_enable = 1'($urandom);
    mem_wr_addr = 5'($urandom_range(0, 3)); wb_wr_addr = 5'($urandom_range(0, 3));
    mem_alu_result = $urandom; wb_data = $urandom;
  endtask

  initial begin
    vecs[0]  = '{6'h20, 32'h7FFFFFFF, 32'h1,        32'h0,    1'b0, 2'd1, 5'd2, 5'd3, 32'h80000000, 4'b1010, 5'd3};
    vecs[1]  = '{6'h22, 32'h3,        32'h0,        32'h5,    1'b1, 2'd1, 5'd2, 5'd7, 32'hFFFFFFFE, 4'b0110, 5'd7};
    vecs[2]  = '{6'h20, 32'hFFFFFFFF, 32'h1,        32'h0,    1'b0, 2'd0, 5'd9, 5'd3, 32'h0,        4'b0101, 5'd9};
    vecs[3]  = '{6'h22, 32'h5,        32'h5,        32'h0,    1'b0, 2'd2, 5'd9, 5'd3, 32'h0,        4'b0001, 5'd31};
    vecs[4]  = '{6'h22, 32'h80000000, 32'h1,        32'h0,    1'b0, 2'd3, 5'd9, 5'd3, 32'h7FFFFFFF, 4'b1000, 5'd0};
    vecs[5]  = '{6'h24, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0,    1'b0, 2'd1, 5'd2, 5'd3, 32'hF000F000, 4'b0010, 5'd3};
    vecs[6]  = '{6'h25, 32'h0F0F0000, 32'h000000F0, 32'h0,    1'b0, 2'd1, 5'd2, 5'd3, 32'h0F0F00F0, 4'b0000, 5'd3};
    vecs[7]  = '{6'h26, 32'hA5A5A5A5, 32'hFFFFFFFF, 32'h0,    1'b0, 2'd1, 5'd2, 5'd3, 32'h5A5A5A5A, 4'b0000, 5'd3};
    vecs[8]  = '{6'h27, 32'h0,        32'h0,        32'h0,    1'b0, 2'd1, 5'd2, 5'd3, 32'hFFFFFFFF, 4'b0010, 5'd3};
    vecs[9]  = '{6'h2A, 32'hFFFFFFFF, 32'h1,        32'h0,    1'b0, 2'd1, 5'd2, 5'd3, 32'h1,        4'b0000, 5'd3};
    vecs[10] = '{6'h2A, 32'h1,        32'hFFFFFFFF, 32'h0,    1'b0, 2'd1, 5'd2, 5'd3, 32'h0,        4'b0001, 5'd3};
    vecs[11] = '{6'h00, 32'h24,       32'h3,        32'h0,    1'b0, 2'd1, 5'd2, 5'd3, 32'h30,       4'b0000, 5'd3};
    vecs[12] = '{6'h02, 32'h1F,       32'h80000000, 32'h0,    1'b0, 2'd1, 5'd2, 5'd3, 32'h1,        4'b0000, 5'd3};
    vecs[13] = '{6'h03, 32'h1F,       32'h80000000, 32'h0,    1'b0, 2'd1, 5'd2, 5'd3, 32'hFFFFFFFF, 4'b0010, 5'd3};
    vecs[14] = '{6'h03, 32'h4,        32'hF0000000, 32'h0,    1'b0, 2'd1, 5'd2, 5'd3, 32'hFF000000, 4'b0010, 5'd3};
    vecs[15] = '{6'h0F, 32'h55,       32'h0,        32'h1234, 1'b1, 2'd1, 5'd2, 5'd3, 32'h12340000, 4'b0000, 5'd3};
    vecs[16] = '{6'h3F, 32'h0,        32'hDEADBEEF, 32'h0,    1'b0, 2'd1, 5'd2, 5'd3, 32'hDEADBEEF, 4'b0010, 5'd3};
    vecs[17] = '{6'h01, 32'h5,        32'h7,        32'h0,    1'b0, 2'd1, 5'd2, 5'd3, 32'h0,        4'b0000, 5'd3};
    vecs[18] = '{6'h20, 32'hA,        32'hFFFF,     32'h5,    1'b1, 2'd1, 5'd2, 5'd3, 32'hF,        4'b0000, 5'd3};

    exp_o = '{default: '0};
    clear_inputs();
    stall = 0; flush = 0;

    // Reset held two cycles under random inputs.
    rst = 1;
    for (int i = 0; i < 2; i++) begin
      rand_inputs();
      stall = 1'($urandom); flush = 1'($urandom);
      cycle("reset");
      chk("reset_result", out_alu_result, 32'h0);
      chk("reset_flags", 32'(out_flags), 32'h0);
      chk("reset_reg_we", 32'(out_reg_write_enable), 32'h0);
    end
    rst = 0; stall = 0; flush = 0;
    clear_inputs();
    in_alu_funct = 6'h20; in_data_rs = 32'd2; in_data_rt = 32'd3; in_reg_write_enable = 1;
    cycle("first");
    chk("first_result", out_alu_result, 32'd5);
    chk("first_reg_we", 32'(out_reg_write_enable), 32'd1);

    // Vector table.
    foreach (vecs[i]) begin
      clear_inputs();
      in_alu_funct = vecs[i].funct; in_rs = 5'd1; in_data_rs = vecs[i].a;
      in_rt = vecs[i].rt; in_data_rt = vecs[i].b; in_imm = vecs[i].imm;
      in_alu_src_mux = vecs[i].alu_src; in_reg_dst_mux = vecs[i].reg_dst; in_rd = vecs[i].rd;
      in_fl_write_enable = 1; in_reg_write_enable = 1;
      cycle("vec");
      chk($sformatf("vec%0d_result", i), out_alu_result, vecs[i].exp_res);
      chk($sformatf("vec%0d_flags", i), 32'(out_flags), 32'(vecs[i].exp_flags));
      chk($sformatf("vec%0d_wr_addr", i), 32'(out_wr_addr), 32'(vecs[i].exp_wr));
    end

    // Forwarding priority.
    clear_inputs();
    in_rs = 5'd4; in_rt = 5'd4; in_data_rs = 32'h99; in_data_rt = 32'h99;
    mem_reg_write_enable = 1; mem_wr_addr = 5'd4; mem_alu_result = 32'h11;
    wb_reg_write_enable = 1; wb_wr_addr = 5'd4; wb_data = 32'h22;
    in_alu_funct = 6'h3F;
    cycle("fwd_mem");
    chk("fwd_mem_result", out_alu_result, 32'h11);
    chk("fwd_mem_store", out_store_data, 32'h11);
    mem_reg_write_enable = 0;
    cycle("fwd_wb");
    chk("fwd_wb_result", out_alu_result, 32'h22);
    chk("fwd_wb_store", out_store_data, 32'h22);
    mem_reg_write_enable = 1; in_alu_funct = 6'h20;
    cycle("fwd_add");
    chk("fwd_add_result", out_alu_result, 32'h22);
    mem_reg_write_enable = 0; wb_reg_write_enable = 0;
    cycle("fwd_rf");
    chk("fwd_rf_store", out_store_data, 32'h99);

    // Stall holds everything, then flush during stall kills control and keeps flags.
    clear_inputs();
    in_alu_funct = 6'h20; in_data_rs = 32'h7FFFFFFF; in_data_rt = 32'h1;
    in_fl_write_enable = 1; in_reg_write_enable = 1;
    cycle("pre_stall");
    stall = 1;
    for (int i = 0; i < 2; i++) begin
      rand_inputs(); in_fl_write_enable = 1;
      cycle("stall");
      chk("stall_result", out_alu_result, 32'h80000000);
      chk("stall_flags", 32'(out_flags), 32'hA);
      chk("stall_reg_we", 32'(out_reg_write_enable), 32'h1);
    end
    flush = 1;
    clear_inputs();
    in_alu_funct = 6'h20; in_data_rs = 32'h1; in_data_rt = 32'h1; in_fl_write_enable = 1;
    {in_is_load, in_mem_write_enable, in_sel_beq_bne, in_sel_jt_jf,
     in_is_branch, in_sel_jflag_branch, in_reg_write_enable} = 7'h7F;
    in_wb_res_mux = 2'd3;
    cycle("flush");
    chk("flush_ctrl",
        32'({out_is_load, out_mem_write_enable, out_sel_beq_bne, out_sel_jt_jf,
             out_is_branch, out_sel_jflag_branch, out_reg_write_enable, out_wb_res_mux}), 32'h0);
    chk("flush_flags", 32'(out_flags), 32'hA);
    stall = 0; flush = 0;

    // Branch target wraps with a negative immediate.
    clear_inputs();
    in_next_pc = 32'h100; in_imm = 32'hFFFFFFF0; in_is_branch = 1;
    cycle("branch");
    chk("branch_target", out_branch_target, 32'hF0);
    chk("branch_flag", 32'(out_is_branch), 32'h1);

    // Mid-stream reset discards the in-flight instruction.
    in_reg_write_enable = 1; in_fl_write_enable = 1; in_alu_funct = 6'h22;
    in_data_rs = 32'h1; in_data_rt = 32'h2;
    rst = 1;
    cycle("midrst");
    chk("midrst_result", out_alu_result, 32'h0);
    chk("midrst_flags", 32'(out_flags), 32'h0);
    rst = 0;

    // Random traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      rand_inputs();
      rst   = ($urandom_range(0, 49) == 0);
      stall = ($urandom_range(0, 4) == 0);
      flush = ($urandom_range(0, 7) == 0);
      cycle("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
